bit_timing_gen: RTL and testbench

Parametrised successor to the fixed 16-sample bit sampling counter used by the serial receive path. It generates oversample ticks from a prescaler and tracks sample progress within each bit. It also counts bits within a frame and emits single-cycle strobes at mid-bit (sample point), end of bit and end of frame. It sits between the start-bit detector and the receive shift register.

---
 rtl/bit_timing_pkg.sv | 21 ++
 rtl/bit_timing_gen_prescaler.sv | 34 +++
 rtl/bit_timing_gen.sv | 143 ++++++++++++++
 tb/tb_bit_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_timing_pkg.sv
// Shared types and width helpers for the receive bit-timing generator.
package bit_timing_pkg;

  // Frame sequencer states: waiting for a start, or timing a frame.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for a modulus n; never narrower than one bit so that
  // degenerate values (n == 1) still give a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Mid-bit sample position for a given oversample ratio (MID = OSR/2).
  function automatic int mid_point(input int osr);
    return osr / 2;
  endfunction

endpackage

// File: rtl/bit_timing_gen_prescaler.sv
// Divide-by-DIV tick generator. The tick is asserted in the cycle whose
// closing edge sees the counter at DIV-1 while enabled; the counter then
// wraps to 0. Shared with the transmit path.
module tick_prescaler
  import bit_timing_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW     = cnt_width(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == C_LAST);
  assign tick      = en && w_at_last;

  // Prescale counter: cleared while idle, frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bit_timing_gen.sv
// Oversampled bit timing for the serial receive path: tracks the position
// inside each bit and the bit number inside each frame, and emits
// registered one-cycle strobes at mid-bit, end of bit and end of frame.
//
// Handshake: start is a level sampled at a clock edge and is only acted
// upon while busy is low (state IDLE); there is no ready/ack, busy is the
// only back-pressure. The frameDone cycle already shows busy low, so a
// start held in that cycle begins the next frame at the following edge.
module bit_timing_gen
  import bit_timing_pkg::*;
#(
  parameter  int OSR        = 16,
  parameter  int DIV        = 1,
  parameter  int FRAME_BITS = 10,
  localparam int PW         = cnt_width(OSR),
  localparam int IW         = cnt_width(FRAME_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          enable,
  output logic [PW-1:0] bitProgress,
  output logic [IW-1:0] bitIndex,
  output logic          sample,
  output logic          bitDone,
  output logic          frameDone,
  output logic          busy,
  output logic          o_dbg_state
);

  localparam logic [PW-1:0] C_PROG_LAST    = PW'(OSR - 1);
  localparam logic [PW-1:0] C_PROG_PRE_MID = PW'(mid_point(OSR) - 1);
  localparam logic [IW-1:0] C_IDX_LAST     = IW'(FRAME_BITS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_prog;
  logic [PW-1:0] w_prog_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_sample;
  logic          r_bit_done;
  logic          r_frame_done;
  logic          w_sample_nxt;
  logic          w_bit_done_nxt;
  logic          w_frame_done_nxt;
  logic          w_run;
  logic          w_tick;
  logic          w_psc_en;
  logic          w_psc_clr;

  assign w_run     = (r_state == RUN);
  assign w_psc_en  = w_run && enable;
  assign w_psc_clr = !w_run;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_psc_clr),
    .en   (w_psc_en),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next counter values and strobe decode. Strobes are decoded
  // from the tick so they last one cycle regardless of DIV.
  always_comb begin
    w_state_nxt      = r_state;
    w_prog_nxt       = r_prog;
    w_idx_nxt        = r_idx;
    w_sample_nxt     = 1'b0;
    w_bit_done_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_prog_nxt = '0;
        w_idx_nxt  = '0;
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_tick) begin
          w_sample_nxt = (r_prog == C_PROG_PRE_MID);
          if (r_prog == C_PROG_LAST) begin
            w_prog_nxt     = '0;
            w_bit_done_nxt = 1'b1;
            if (r_idx == C_IDX_LAST) begin
              // Last bit: index returns to 0 in the same cycle as the
              // frame strobe, so FRAME_BITS itself is never shown.
              w_idx_nxt        = '0;
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = IDLE;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_prog_nxt = r_prog + PW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counter and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prog       <= '0;
      r_idx        <= '0;
      r_sample     <= 1'b0;
      r_bit_done   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_prog       <= w_prog_nxt;
      r_idx        <= w_idx_nxt;
      r_sample     <= w_sample_nxt;
      r_bit_done   <= w_bit_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bitProgress = r_prog;
  assign bitIndex    = r_idx;
  assign sample      = r_sample;
  assign bitDone     = r_bit_done;
  assign frameDone   = r_frame_done;
  assign busy        = w_run;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bit_timing_gen.sv
// Bench for bit_timing_gen: three instances (default, DIV=4, OSR=8 with a
// one-bit frame). Each run records per-cycle outputs relative to the edge
// that accepts start; a table of hand-computed checkpoints and strobe
// counts is then compared against that record.
module tb_bit_timing_gen;

  logic       clk = 1'b0;
  logic [2:0] rst_v    = 3'b111;
  logic [2:0] start_v  = 3'b000;
  logic [2:0] enable_v = 3'b111;

  logic [3:0] a_prog, b_prog;
  logic [3:0] a_idx,  b_idx;
  logic [2:0] c_prog;
  logic [0:0] c_idx;
  logic a_s, a_bd, a_fd, a_busy, a_dbg;
  logic b_s, b_bd, b_fd, b_busy, b_dbg;
  logic c_s, c_bd, c_fd, c_busy, c_dbg;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bit_timing_gen #(.OSR(16), .DIV(1), .FRAME_BITS(10)) u_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .enable(enable_v[0]),
    .bitProgress(a_prog), .bitIndex(a_idx), .sample(a_s), .bitDone(a_bd),
    .frameDone(a_fd), .busy(a_busy), .o_dbg_state(a_dbg));

  bit_timing_gen #(.OSR(16), .DIV(4), .FRAME_BITS(10)) u_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .enable(enable_v[1]),
    .bitProgress(b_prog), .bitIndex(b_idx), .sample(b_s), .bitDone(b_bd),
    .frameDone(b_fd), .busy(b_busy), .o_dbg_state(b_dbg));

  bit_timing_gen #(.OSR(8), .DIV(1), .FRAME_BITS(1)) u_c (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .enable(enable_v[2]),
    .bitProgress(c_prog), .bitIndex(c_idx), .sample(c_s), .bitDone(c_bd),
    .frameDone(c_fd), .busy(c_busy), .o_dbg_state(c_dbg));

  typedef struct {
    int   prog;
    int   idx;
    logic s;
    logic bd;
    logic fd;
    logic busy;
    logic dbg;
  } snap_t;

  typedef struct {
    int    scen;
    int    k;
    snap_t exp;
  } vec_t;

  snap_t hist[0:700];
  int    last_n;
  vec_t  vecs[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic snap_t get_snap(input int d);
    snap_t r;
    case (d)
      0:       r = '{int'(a_prog), int'(a_idx), a_s, a_bd, a_fd, a_busy, a_dbg};
      1:       r = '{int'(b_prog), int'(b_idx), b_s, b_bd, b_fd, b_busy, b_dbg};
      default: r = '{int'(c_prog), int'(c_idx), c_s, c_bd, c_fd, c_busy, c_dbg};
    endcase
    return r;
  endfunction

  // Reset, accept a start (offset 0), then run n more edges. Enable is
  // dropped for edges frz_at+1 .. frz_at+frz_len; start is raised for
  // edges rs1/rs2 and rst for edge rst_k (use -1 for none).
  task automatic run_frame(input int d, input int n, input int frz_at,
                           input int frz_len, input int rs1, input int rs2,
                           input int rst_k);
    enable_v[d] = 1'b1;
    start_v[d]  = 1'b0;
    rst_v[d]    = 1'b1;
    step();
    rst_v[d]    = 1'b0;
    start_v[d]  = 1'b1;
    step();
    start_v[d]  = 1'b0;
    hist[0]     = get_snap(d);
    for (int k = 1; k <= n; k++) begin
      enable_v[d] = !(frz_len > 0 && k > frz_at && k <= frz_at + frz_len);
      start_v[d]  = (k == rs1) || (k == rs2);
      rst_v[d]    = (k == rst_k);
      step();
      hist[k] = get_snap(d);
    end
    start_v[d]  = 1'b0;
    rst_v[d]    = 1'b0;
    enable_v[d] = 1'b1;
    last_n      = n;
  endtask

  // ---------------- scoreboard ----------------
  task automatic add(input int scen, input int k, input int prog, input int idx,
                     input logic s, input logic bd, input logic fd, input logic bz);
    vec_t v;
    v.scen = scen;
    v.k    = k;
    v.exp  = '{prog, idx, s, bd, fd, bz, bz};
    vecs.push_back(v);
  endtask

  task automatic check_snap(input string name, input snap_t got, input snap_t exp);
    total++;
    if (got.prog !== exp.prog || got.idx !== exp.idx || got.s !== exp.s ||
        got.bd !== exp.bd || got.fd !== exp.fd || got.busy !== exp.busy ||
        got.dbg !== exp.dbg) begin
      bad++;
      $display("FAIL %s got prog=%0d idx=%0d s=%b bd=%b fd=%b busy=%b st=%b want prog=%0d idx=%0d s=%b bd=%b fd=%b busy=%b st=%b",
               name, got.prog, got.idx, got.s, got.bd, got.fd, got.busy, got.dbg,
               exp.prog, exp.idx, exp.s, exp.bd, exp.fd, exp.busy, exp.dbg);
    end
  endtask

  task automatic check_scen(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        check_snap($sformatf("s%0d_k%0d", scen, vecs[i].k), hist[vecs[i].k], vecs[i].exp);
      end
    end
  endtask

  task automatic check_counts(input int scen, input int es, input int ebd, input int efd);
    int ns, nbd, nfd;
    ns = 0; nbd = 0; nfd = 0;
    for (int k = 0; k <= last_n; k++) begin
      ns  += int'(hist[k].s  === 1'b1);
      nbd += int'(hist[k].bd === 1'b1);
      nfd += int'(hist[k].fd === 1'b1);
    end
    total++;
    if (ns != es || nbd != ebd || nfd != efd) begin
      bad++;
      $display("FAIL s%0d_counts got sample=%0d bitDone=%0d frameDone=%0d want %0d %0d %0d",
               scen, ns, nbd, nfd, es, ebd, efd);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    snap_t zero;
    zero = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // 1: default timeline
    add(1,   0, 0, 0, 0, 0, 0, 1);
    add(1,   7, 7, 0, 0, 0, 0, 1);
    add(1,   8, 8, 0, 1, 0, 0, 1);
    add(1,   9, 9, 0, 0, 0, 0, 1);
    add(1,  16, 0, 1, 0, 1, 0, 1);
    add(1,  17, 1, 1, 0, 0, 0, 1);
    add(1,  24, 8, 1, 1, 0, 0, 1);
    add(1, 152, 8, 9, 1, 0, 0, 1);
    add(1, 159, 15, 9, 0, 0, 0, 1);
    add(1, 160, 0, 0, 0, 1, 1, 0);
    add(1, 161, 0, 0, 0, 0, 0, 0);
    // 2: enable low for 5 edges at bit 2, progress 5
    add(2,  37, 5, 2, 0, 0, 0, 1);
    add(2,  38, 5, 2, 0, 0, 0, 1);
    add(2,  40, 5, 2, 0, 0, 0, 1);
    add(2,  42, 5, 2, 0, 0, 0, 1);
    add(2,  43, 6, 2, 0, 0, 0, 1);
    add(2,  45, 8, 2, 1, 0, 0, 1);
    add(2, 164, 15, 9, 0, 0, 0, 1);
    add(2, 165, 0, 0, 0, 1, 1, 0);
    // 3: DIV=4
    add(3,   3, 0, 0, 0, 0, 0, 1);
    add(3,   4, 1, 0, 0, 0, 0, 1);
    add(3,  31, 7, 0, 0, 0, 0, 1);
    add(3,  32, 8, 0, 1, 0, 0, 1);
    add(3,  33, 8, 0, 0, 0, 0, 1);
    add(3,  64, 0, 1, 0, 1, 0, 1);
    add(3,  65, 0, 1, 0, 0, 0, 1);
    add(3, 639, 15, 9, 0, 0, 0, 1);
    add(3, 640, 0, 0, 0, 1, 1, 0);
    // 4: start ignored while busy; start in frameDone cycle accepted
    add(4,  50, 2, 3, 0, 0, 0, 1);
    add(4,  56, 8, 3, 1, 0, 0, 1);
    add(4, 160, 0, 0, 0, 1, 1, 0);
    add(4, 161, 0, 0, 0, 0, 0, 1);
    add(4, 162, 1, 0, 0, 0, 0, 1);
    add(4, 169, 8, 0, 1, 0, 0, 1);
    // 5: reset mid-frame
    add(5,  69, 5, 4, 0, 0, 0, 1);
    add(5,  70, 0, 0, 0, 0, 0, 0);
    add(5,  71, 0, 0, 0, 0, 0, 0);
    // 6: fresh frame after reset
    add(6,   0, 0, 0, 0, 0, 0, 1);
    add(6,   8, 8, 0, 1, 0, 0, 1);
    add(6,  16, 0, 1, 0, 1, 0, 1);
    // 7: OSR=8, one-bit frame
    add(7,   0, 0, 0, 0, 0, 0, 1);
    add(7,   4, 4, 0, 1, 0, 0, 1);
    add(7,   7, 7, 0, 0, 0, 0, 1);
    add(7,   8, 0, 0, 0, 1, 1, 0);
    add(7,   9, 0, 0, 0, 0, 0, 0);

    // reset state of every instance
    rst_v = 3'b111;
    step();
    step();
    check_snap("reset_a", get_snap(0), zero);
    check_snap("reset_b", get_snap(1), zero);
    check_snap("reset_c", get_snap(2), zero);
    rst_v = 3'b000;
    step();

    run_frame(0, 161, -1, 0, -1, -1, -1);
    check_scen(1);
    check_counts(1, 10, 10, 1);

    run_frame(0, 166, 37, 5, -1, -1, -1);
    check_scen(2);
    check_counts(2, 10, 10, 1);

    run_frame(1, 641, -1, 0, -1, -1, -1);
    check_scen(3);
    check_counts(3, 10, 10, 1);

    run_frame(0, 170, -1, 0, 50, 161, -1);
    check_scen(4);
    check_counts(4, 11, 10, 1);

    run_frame(0, 80, -1, 0, -1, -1, 70);
    check_scen(5);
    check_counts(5, 4, 4, 0);

    run_frame(0, 20, -1, 0, -1, -1, -1);
    check_scen(6);
    check_counts(6, 1, 1, 0);

    run_frame(2, 9, -1, 0, -1, -1, -1);
    check_scen(7);
    check_counts(7, 1, 1, 1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
